// File: rtl/led_sequencer.sv
// LED pattern sequencer fed by a slow divided clock: rising edges of div_i become
// ticks, every TICKS_PER_STEP ticks the LED register advances one pattern step.
module led_sequencer #(
  parameter int WIDTH          = 8,
  parameter int TICKS_PER_STEP = 1
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             div_i,
  input  logic [1:0]       mode_i,
  input  logic             run_i,
  output logic [WIDTH-1:0] leds_o,
  output logic             step_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [1:0] MODE_ROL    = 2'd0;
  localparam logic [1:0] MODE_ROR    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  localparam logic [7:0] TCNT_LAST = 8'(TICKS_PER_STEP - 1);

  // dir: 0 = moving towards the MSB (left), 1 = moving towards bit 0 (right)
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  state_e           state_q, state_d;
  logic             div_q;
  logic [7:0]       tcnt_q, tcnt_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic             step_q, step_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;

  logic             tick;
  logic [WIDTH-1:0] pat_leds;
  logic             pat_dir;

  assign tick = div_i & ~div_q;

  function automatic logic [WIDTH-1:0] seed(input logic [1:0] m);
    logic [WIDTH-1:0] s;
    s = '0;
    case (m)
      MODE_ROL, MODE_BOUNCE: s[0] = 1'b1;
      MODE_ROR:              s[WIDTH-1] = 1'b1;
      default:               s = '0;
    endcase
    return s;
  endfunction

  // Next pattern value for the currently latched mode.
  always_comb begin
    pat_leds = leds_q;
    pat_dir  = dir_q;
    case (mode_q)
      MODE_ROL: pat_leds = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
      MODE_ROR: pat_leds = {leds_q[0], leds_q[WIDTH-1:1]};
      MODE_BOUNCE: begin
        if (dir_q == DIR_LEFT) begin
          if (leds_q[WIDTH-1]) begin
            pat_leds = leds_q >> 1;
            pat_dir  = DIR_RIGHT;
          end else begin
            pat_leds = leds_q << 1;
          end
        end else begin
          if (leds_q[0]) begin
            pat_leds = leds_q << 1;
            pat_dir  = DIR_LEFT;
          end else begin
            pat_leds = leds_q >> 1;
          end
        end
      end
      MODE_COUNT: pat_leds = leds_q + WIDTH'(1);
      default:    pat_leds = leds_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    leds_d  = leds_q;
    step_d  = 1'b0;
    mode_d  = mode_q;
    dir_d   = dir_q;
    case (state_q)
      ST_LOAD: begin
        leds_d  = seed(mode_i);
        mode_d  = mode_i;
        dir_d   = DIR_LEFT;
        step_d  = 1'b1;
        state_d = run_i ? ST_RUN : ST_HOLD;
      end
      ST_RUN: begin
        // run_i low wins over a coincident tick
        if (!run_i) begin
          state_d = ST_HOLD;
        end else if (tick) begin
          if (tcnt_q == TCNT_LAST) begin
            tcnt_d = '0;
            step_d = 1'b1;
            if (mode_i != mode_q) begin
              leds_d = seed(mode_i);
              mode_d = mode_i;
              dir_d  = DIR_LEFT;
            end else begin
              leds_d = pat_leds;
              dir_d  = pat_dir;
            end
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end
      ST_HOLD: begin
        if (run_i) state_d = ST_RUN;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_LOAD;
      div_q   <= 1'b0;
      tcnt_q  <= '0;
      leds_q  <= '0;
      step_q  <= 1'b0;
      mode_q  <= MODE_ROL;
      dir_q   <= DIR_LEFT;
    end else begin
      state_q <= state_d;
      div_q   <= div_i;
      tcnt_q  <= tcnt_d;
      leds_q  <= leds_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end

  assign leds_o  = leds_q;
  assign step_o  = step_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Randomised bench for led_sequencer: two instances (1 and 3 ticks per step) share
// stimulus; a reference model queues the expected {step_o, leds_o} of every cycle.
module tb_led_sequencer;

  localparam int W     = 4;
  localparam int TPS_A = 1;
  localparam int TPS_B = 3;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         div   = 1'b0;
  logic         run   = 1'b0;
  logic [1:0]   mode  = 2'd0;
  logic [W-1:0] leds_a, leds_b;
  logic         step_a, step_b;
  logic [1:0]   st_a, st_b;

  led_sequencer #(.WIDTH(W), .TICKS_PER_STEP(TPS_A)) u_a (
    .clock_i(clk), .reset_ni(rst_n), .div_i(div), .mode_i(mode), .run_i(run),
    .leds_o(leds_a), .step_o(step_a), .state_o(st_a)
  );

  led_sequencer #(.WIDTH(W), .TICKS_PER_STEP(TPS_B)) u_b (
    .clock_i(clk), .reset_ni(rst_n), .div_i(div), .mode_i(mode), .run_i(run),
    .leds_o(leds_b), .step_o(step_b), .state_o(st_b)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // phase: 0 = loading, 1 = running, 2 = holding
  int   ph[2];
  int   cnt[2];
  int   val[2];
  int   mmode[2];
  bit   going_right[2];
  bit   div_prev;
  int   tps[2] = '{TPS_A, TPS_B};

  logic [W:0] exp_q0[$];
  logic [W:0] exp_q1[$];

  int checks = 0;
  int errors = 0;

  function automatic int seed_of(input int m);
    if (m == 1) return 1 << (W - 1);
    if (m == 3) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; cnt[k] = 0; val[k] = 0; mmode[k] = 0; going_right[k] = 0;
    end
    div_prev = 0;
  endtask

  task automatic advance(input int k);
    int v;
    int p;
    v = val[k];
    p = 0;
    case (mmode[k])
      0: val[k] = (v * 2) % (1 << W) + v / (1 << (W - 1));
      1: val[k] = v / 2 + (v % 2) * (1 << (W - 1));
      2: begin
        for (int i = 0; i < W; i++) if (v == (1 << i)) p = i;
        if (!going_right[k]) begin
          if (p == W - 1) begin going_right[k] = 1; p = W - 2; end
          else p = p + 1;
        end else begin
          if (p == 0) begin going_right[k] = 0; p = 1; end
          else p = p - 1;
        end
        val[k] = 1 << p;
      end
      default: val[k] = (v + 1) % (1 << W);
    endcase
  endtask

  // Predicts what the next rising clock edge does with the inputs now applied.
  task automatic model_cycle();
    bit tick;
    bit stp;
    logic [W-1:0] lv;
    tick = div && !div_prev;
    div_prev = div;
    for (int k = 0; k < 2; k++) begin
      stp = 0;
      if (ph[k] == 0) begin
        val[k] = seed_of(int'(mode)); mmode[k] = int'(mode); going_right[k] = 0;
        stp = 1;
        ph[k] = run ? 1 : 2;
      end else if (ph[k] == 1) begin
        if (!run) ph[k] = 2;
        else if (tick) begin
          if (cnt[k] == tps[k] - 1) begin
            cnt[k] = 0;
            stp = 1;
            if (int'(mode) != mmode[k]) begin
              val[k] = seed_of(int'(mode)); mmode[k] = int'(mode); going_right[k] = 0;
            end else begin
              advance(k);
            end
          end else begin
            cnt[k] = cnt[k] + 1;
          end
        end
      end else begin
        if (run) ph[k] = 1;
      end
      lv = val[k][W-1:0];
      if (k == 0) exp_q0.push_back({stp, lv});
      else        exp_q1.push_back({stp, lv});
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got step=%b leds=%b, expected step=%b leds=%b",
               name, $time, got[W], got[W-1:0], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic pop_check(input int k);
    logic [W:0] got;
    logic [W:0] exp;
    got = (k == 0) ? {step_a, leds_a} : {step_b, leds_b};
    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL underflow_%0d at %0t: output step=%b leds=%b with no expectation",
               k, $time, got[W], got[W-1:0]);
    end else begin
      exp = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check(k == 0 ? "cycle_a" : "cycle_b", got, exp);
    end
  endtask

  always begin
    @(negedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      check("reset_a", {step_a, leds_a}, '0);
      check("reset_b", {step_b, leds_b}, '0);
    end else begin
      pop_check(0);
      pop_check(1);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic d, input logic r, input logic [1:0] m);
    @(posedge clk);
    #2;
    div = d; run = r; mode = m;
    if (rst_n) model_cycle();
  endtask

  task automatic pulse(input logic r, input logic [1:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, r, m);
      drive(1'b0, r, m);
    end
  endtask

  // Asserted mid-cycle, away from any clock edge.
  task automatic assert_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
  endtask

  task automatic release_reset(input logic d, input logic r, input logic [1:0] m);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    div = d; run = r; mode = m;
    exp_q0.push_back('0);
    exp_q1.push_back('0);
    model_cycle();
  endtask

  initial begin
    logic       d;
    logic       r;
    logic [1:0] m;
    model_reset();
    repeat (3) @(posedge clk);
    release_reset(1'b0, 1'b1, 2'd0);
    drive(1'b0, 1'b1, 2'd0);
    pulse(1'b1, 2'd0, 5);             // rotate left
    pulse(1'b1, 2'd3, 20);            // count, wraps in the 1-tick instance
    pulse(1'b1, 2'd2, 12);            // bounce
    pulse(1'b0, 2'd2, 5);             // hold: frozen
    pulse(1'b1, 2'd2, 4);
    pulse(1'b1, 2'd0, 6);
    drive(1'b0, 1'b1, 2'd1);          // mode change between steps
    pulse(1'b1, 2'd1, 4);
    drive(1'b1, 1'b0, 2'd1);          // tick together with run falling
    drive(1'b0, 1'b0, 2'd1);
    drive(1'b0, 1'b1, 2'd1);
    pulse(1'b1, 2'd1, 3);
    pulse(1'b1, 2'd3, 11);
    assert_reset();
    drive(1'b0, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 2'd0);
    release_reset(1'b1, 1'b1, 2'd3);  // div already high at release
    drive(1'b0, 1'b1, 2'd3);
    pulse(1'b1, 2'd3, 4);
    m = 2'd0;
    for (int i = 0; i < 600; i++) begin
      d = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 249) == 0) begin
        assert_reset();
        drive(d, r, m);
        release_reset(1'($urandom_range(0, 1)), r, m);
      end else begin
        drive(d, r, m);
      end
    end
    drive(1'b0, 1'b1, m);
    drive(1'b0, 1'b1, m);
    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
